// File: rtl/aes_mix_columns_seq_if.sv
// Block-level handshake bundle for the MixColumns engine: an input block channel
// and a result channel, each with valid/ready.
interface aes_mix_columns_seq_if;
  logic         inValid;
  logic         inReady;
  logic         inInverse;
  logic [127:0] inData;
  logic         outValid;
  logic         outReady;
  logic [127:0] outData;
  logic         outInverse;

  // Engine side
  modport slave (
    input  inValid, inInverse, inData, outReady,
    output inReady, outValid, outData, outInverse
  );

  // Producer/consumer side
  modport master (
    output inValid, inInverse, inData, outReady,
    input  inReady, outValid, outData, outInverse
  );
endinterface

// File: rtl/aes_mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns over a full 128-bit state, processing
// COLS_PER_CYCLE columns per clock with a registered result and valid/ready flow.
module aes_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input logic                  clk,
  input logic                  rst,
  aes_mix_columns_seq_if.slave bus
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : gBadCols
    $error("aes_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int         N    = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST = 2'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t       stateReg;
  state_t       stateNext;
  logic [1:0]   cntReg;
  logic [127:0] workReg;
  logic [127:0] resultReg;
  logic         modeReg;
  logic         inReadyInt;
  logic         outValidInt;
  logic         accept;
  logic [31:0]  slotOut [COLS_PER_CYCLE];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Every coefficient used (1,2,3,9,B,D,E) fits in 4 bits, so it is built from a, 2a, 4a, 8a.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] a2;
    logic [7:0] a4;
    logic [7:0] a8;
    a2 = xtime(a);
    a4 = xtime(a2);
    a8 = xtime(a4);
    return ({8{k[0]}} & a) ^ ({8{k[1]}} & a2) ^ ({8{k[2]}} & a4) ^ ({8{k[3]}} & a8);
  endfunction

  // Both matrices are circulant: row r uses the first row rotated right by r.
  function automatic logic [31:0] mixColumn(input logic [31:0] col, input logic inv);
    logic [3:0][3:0] coef;
    logic [7:0]      acc;
    logic [31:0]     res;
    coef = inv ? {4'h9, 4'hd, 4'hb, 4'he} : {4'h1, 4'h1, 4'h3, 4'h2};
    res  = '0;
    for (int r = 0; r < 4; r++) begin
      acc = '0;
      for (int j = 0; j < 4; j++) begin
        acc = acc ^ gmul(col[31 - 8*j -: 8], coef[(j - r + 4) % 4]);
      end
      res[31 - 8*r -: 8] = acc;
    end
    return res;
  endfunction

  for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : gSlot
    logic [1:0]  colIdx;
    logic [31:0] colIn;

    assign colIdx = 2'(int'(cntReg) * COLS_PER_CYCLE + gi);

    always_comb begin
      colIn = workReg[127:96];
      case (colIdx)
        2'd0: colIn = workReg[127:96];
        2'd1: colIn = workReg[95:64];
        2'd2: colIn = workReg[63:32];
        2'd3: colIn = workReg[31:0];
        default: colIn = workReg[127:96];
      endcase
    end

    assign slotOut[gi] = mixColumn(colIn, modeReg);
  end

  always_comb begin
    stateNext   = stateReg;
    inReadyInt  = 1'b0;
    outValidInt = 1'b0;
    case (stateReg)
      IDLE: begin
        inReadyInt = 1'b1;
        if (bus.inValid) stateNext = CALC;
      end
      CALC: begin
        if (cntReg == LAST) stateNext = DONE;
      end
      DONE: begin
        outValidInt = 1'b1;
        // Accepting while the result drains avoids a bubble between blocks.
        inReadyInt  = bus.outReady;
        if (bus.outReady) stateNext = bus.inValid ? CALC : IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign accept = bus.inValid & inReadyInt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= IDLE;
      cntReg   <= 2'd0;
      workReg  <= '0;
      modeReg  <= 1'b0;
    end else begin
      stateReg <= stateNext;
      if (accept) begin
        workReg <= bus.inData;
        modeReg <= bus.inInverse;
        cntReg  <= 2'd0;
      end else if (stateReg == CALC) begin
        cntReg <= (cntReg == LAST) ? 2'd0 : cntReg + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resultReg <= '0;
    end else if (stateReg == CALC) begin
      for (int c = 0; c < 4; c++) begin
        if (cntReg == 2'(c / COLS_PER_CYCLE)) begin
          resultReg[127 - 32*c -: 32] <= slotOut[c % COLS_PER_CYCLE];
        end
      end
    end
  end

  assign bus.inReady    = inReadyInt;
  assign bus.outValid   = outValidInt;
  assign bus.outData    = resultReg;
  assign bus.outInverse = modeReg;

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// Directed + random bench for aes_mix_columns_seq with 1, 2 and 4 columns per cycle,
// scoreboard-checked against an independent GF(2^8) reference model.
module tb_aes_mix_columns_seq;

  typedef struct packed {
    logic [127:0] d;
    logic         inv;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         inValidA  [3];
  logic         inInvA    [3];
  logic [127:0] inDataA   [3];
  logic         outReadyA [3];
  logic         inReadyA  [3];
  logic         outValidA [3];
  logic         outInvA   [3];
  logic [127:0] outDataA  [3];
  int           xferCnt   [3] = '{0, 0, 0};

  exp_t sb[$];
  int   passCnt  = 0;
  int   totalCnt = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : gDut
    aes_mix_columns_seq_if bus ();
    assign bus.inValid    = inValidA[gi];
    assign bus.inInverse  = inInvA[gi];
    assign bus.inData     = inDataA[gi];
    assign bus.outReady   = outReadyA[gi];
    assign inReadyA[gi]   = bus.inReady;
    assign outValidA[gi]  = bus.outValid;
    assign outInvA[gi]    = bus.outInverse;
    assign outDataA[gi]   = bus.outData;

    aes_mix_columns_seq #(.COLS_PER_CYCLE(1 << gi)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++)
      if (outValidA[k] && outReadyA[k]) xferCnt[k] <= xferCnt[k] + 1;
  end

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [127:0] mixRef(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      if (!inv) begin
        r[127 - 32*c -: 8] = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
        r[119 - 32*c -: 8] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
        r[111 - 32*c -: 8] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
        r[103 - 32*c -: 8] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
      end else begin
        r[127 - 32*c -: 8] = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
        r[119 - 32*c -: 8] = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
        r[111 - 32*c -: 8] = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
        r[103 - 32*c -: 8] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    totalCnt++;
    assert (obs === exp) begin
      passCnt++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the engine ready; returns at the negedge after the accept edge.
  task automatic sendBlock(input int k, input logic [127:0] d, input logic inv,
                           input logic [127:0] expD, input logic expInv);
    exp_t e;
    check($sformatf("inReady_before_send_k%0d", k), 128'(inReadyA[k]), 128'd1);
    inValidA[k] = 1'b1;
    inDataA[k]  = d;
    inInvA[k]   = inv;
    e.d = expD;
    e.inv = expInv;
    sb.push_back(e);
    @(negedge clk);
    inValidA[k] = 1'b0;
    inDataA[k]  = rand128();
  endtask

  task automatic recvBlock(input int k, input int expLat, input bit toggle, input string tag);
    int   lat;
    exp_t e;
    lat = 0;
    while (!outValidA[k] && lat < 40) begin
      @(negedge clk);
      lat++;
      if (toggle) inInvA[k] = ~inInvA[k];
    end
    check({tag, "_latency"}, 128'(lat), 128'(expLat));
    check({tag, "_outValid"}, 128'(outValidA[k]), 128'd1);
    if (sb.size() == 0) begin
      totalCnt++;
      $error("FAIL %s_scoreboard: observed empty queue expected one entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_outData"}, outDataA[k], e.d);
      check({tag, "_outInverse"}, 128'(outInvA[k]), 128'(e.inv));
      $display("blk %s k=%0d lat=%0d inv=%0d data=%h", tag, k, lat, outInvA[k], outDataA[k]);
    end
  endtask

  initial begin
    logic [127:0] fwdIn, fwdOut, invIn, invOut, d, held;
    logic         m;
    int           x0;

    fwdIn  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    fwdOut = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    invIn  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
    invOut = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      inValidA[k] = 1'b0; inInvA[k] = 1'b0; inDataA[k] = '0; outReadyA[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_outValid_k%0d", k), 128'(outValidA[k]), 128'd0);
      check($sformatf("reset_outData_k%0d", k), outDataA[k], 128'd0);
      check($sformatf("reset_outInverse_k%0d", k), 128'(outInvA[k]), 128'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      check($sformatf("post_reset_inReady_k%0d", k), 128'(inReadyA[k]), 128'd1);

    // Forward, one column per cycle
    sendBlock(0, fwdIn, 1'b0, fwdOut, 1'b0);
    check("fwd1_inReady_calc", 128'(inReadyA[0]), 128'd0);
    recvBlock(0, 4, 1'b0, "fwd1");
    @(negedge clk);
    check("fwd1_idle_outValid", 128'(outValidA[0]), 128'd0);

    // Inverse, all four columns in one cycle
    sendBlock(2, invIn, 1'b1, invOut, 1'b1);
    recvBlock(2, 1, 1'b0, "inv4");
    @(negedge clk);

    // Backpressure, two columns per cycle
    outReadyA[1] = 1'b0;
    x0 = xferCnt[1];
    sendBlock(1, fwdIn, 1'b0, fwdOut, 1'b0);
    recvBlock(1, 2, 1'b0, "bp2");
    held = outDataA[1];
    for (int i = 0; i < 10; i++) begin
      inValidA[1] = 1'b1;
      inDataA[1]  = rand128();
      @(negedge clk);
      check($sformatf("bp2_hold%0d_outValid", i), 128'(outValidA[1]), 128'd1);
      check($sformatf("bp2_hold%0d_outData", i), outDataA[1], held);
      check($sformatf("bp2_hold%0d_inReady", i), 128'(inReadyA[1]), 128'd0);
    end
    inValidA[1]  = 1'b0;
    outReadyA[1] = 1'b1;
    @(negedge clk);
    check("bp2_release_outValid", 128'(outValidA[1]), 128'd0);
    check("bp2_release_inReady", 128'(inReadyA[1]), 128'd1);
    @(negedge clk);
    check("bp2_single_transfer", 128'(xferCnt[1] - x0), 128'd1);

    // Back-to-back: second block accepted as the first drains
    x0 = xferCnt[0];
    begin
      exp_t e;
      check("b2b_inReady_first", 128'(inReadyA[0]), 128'd1);
      inValidA[0] = 1'b1; inDataA[0] = fwdIn; inInvA[0] = 1'b0;
      e.d = fwdOut; e.inv = 1'b0; sb.push_back(e);
      @(negedge clk);
      inDataA[0] = invIn; inInvA[0] = 1'b1;
      e.d = invOut; e.inv = 1'b1; sb.push_back(e);
    end
    recvBlock(0, 4, 1'b0, "b2b_first");
    check("b2b_inReady_in_done", 128'(inReadyA[0]), 128'd1);
    @(negedge clk);
    inValidA[0] = 1'b0;
    recvBlock(0, 4, 1'b0, "b2b_second");
    @(negedge clk);
    check("b2b_transfers", 128'(xferCnt[0] - x0), 128'd2);

    // Mode latched at accept despite toggling afterwards
    for (int t = 0; t < 2; t++) begin
      m = (t == 1);
      d = rand128();
      sendBlock(0, d, m, mixRef(d, m), m);
      recvBlock(0, 4, 1'b1, $sformatf("modelatch%0d", t));
      @(negedge clk);
    end

    // Reset in the middle of CALC (counter = 2)
    d = rand128();
    sendBlock(0, d, 1'b0, mixRef(d, 1'b0), 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_outValid_during", 128'(outValidA[0]), 128'd0);
    check("midrst_outData_during", outDataA[0], 128'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_outValid_after", 128'(outValidA[0]), 128'd0);
    check("midrst_inReady_after", 128'(inReadyA[0]), 128'd1);
    d = rand128();
    sendBlock(0, d, 1'b1, mixRef(d, 1'b1), 1'b1);
    recvBlock(0, 4, 1'b0, "midrst_next");
    @(negedge clk);

    // Random blocks on every configuration
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) begin
        d = rand128();
        m = 1'($urandom_range(0, 1));
        sendBlock(k, d, m, mixRef(d, m), m);
        recvBlock(k, 4 >> k, 1'b0, $sformatf("rand_k%0d_%0d", k, i));
        @(negedge clk);
      end
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/aes_mix_columns_seq.md
Name: aes_mix_columns_seq

Overview:
- Sequential MixColumns / InvMixColumns engine for a full 128-bit AES state, replacing the single-column combinational inverse-only function.
- Forward or inverse transform is selectable per block.
- Column parallelism is set at elaboration, trading area against latency.
- Sits between the SubBytes/ShiftRows stage and AddRoundKey in the round datapath, with valid/ready handshakes on both sides.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock. Legal values 1, 2, 4; any other value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- inValid  input  1  input block valid
- inReady  output  1  engine can accept a block
- inInverse  input  1  0 = MixColumns, 1 = InvMixColumns; sampled on accept
- inData  input  128  state; [127:96] = column 0 (byte [127:120] = row 0), ..., [31:0] = column 3
- outValid  output  1  result valid
- outReady  input  1  downstream accepts result
- outData  output  128  transformed state, same layout as inData
- outInverse  output  1  mode the result was computed with

Behaviour:
- Reset: asynchronous on rst high.
  - State returns to IDLE.
  - Column counter = 0.
  - outValid = 0, outData = 0, outInverse = 0.
  - inReady = 1 once rst is low.
  - Any in-flight block is discarded; no partial result is ever presented.
- Iteration count: N = 4 / COLS_PER_CYCLE (4, 2 or 1). Counter width 2 bits; it counts 0..N-1 and wraps to 0.
- FSM states: IDLE, CALC, DONE.
  - IDLE: inReady = 1. On inValid=1 at a clock edge: capture inData into the work register, capture inInverse, clear the counter, go to CALC.
  - CALC: inReady = 0. Each cycle, transform columns counter*COLS_PER_CYCLE .. counter*COLS_PER_CYCLE+COLS_PER_CYCLE-1 (lowest column index = most significant bits) and write them into the result register. Increment the counter. When counter = N-1, go to DONE.
  - DONE: outValid = 1. outData and outInverse are held stable until outReady=1.
    - On outReady=1 with inValid=0: go to IDLE.
    - inReady = outReady in DONE (combinational). A block presented in the same cycle as outReady is accepted and the FSM goes directly to CALC, so no bubble cycle is inserted.
- Latency: block accepted at edge 0; outValid rises after edge N. outData is registered, with no combinational path from inData.
- Throughput: one block per N+1 cycles when downstream is always ready.
- Per-column arithmetic (bytes a0..a3 = rows 0..3), GF(2^8) modulo x^8+x^4+x^3+x+1:
  - Forward matrix rows: (02,03,01,01), (01,02,03,01), (01,01,02,03), (03,01,01,02).
  - Inverse matrix rows: (0E,0B,0D,09), (09,0E,0B,0D), (0D,09,0E,0B), (0B,0D,09,0E).
  - Each output byte is the XOR of its four products.
- Mode handling: the mode is latched at accept. Toggling inInverse during CALC or DONE has no effect on the current block.
- Handshake rules:
  - inValid/inData may change freely while inReady=0.
  - outValid never drops without outReady.
  - outData never changes while outValid=1 and outReady=0.
- Unused input data in CALC is ignored.

Test Plan:
- Forward, COLS_PER_CYCLE=1: inData = db135345_f20a225c_01010101_c6c6c6c6, inInverse=0 -> outData = 8e4da1bc_9fdc589d_01010101_c6c6c6c6; outValid rises exactly 4 cycles after accept.
- Inverse round-trip, COLS_PER_CYCLE=4: inData = 8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, inInverse=1 -> outData = db135345_f20a225c_d4d4d4d5_2d26314c; latency 1 cycle; outInverse=1.
- Backpressure, COLS_PER_CYCLE=2: hold outReady=0 for 10 cycles after outValid -> outData stable, inReady=0 throughout; release outReady -> single transfer, then IDLE.
- Back-to-back: inValid held high with two blocks (forward then inverse), outReady=1 -> second block accepted in the same cycle the first is consumed; results 8e4da1bc... then db135345...; no gap cycle.
- Mode latch: toggle inInverse every cycle during CALC -> result matches the mode sampled at accept.
- Reset mid-CALC: assert rst at counter=2 (COLS_PER_CYCLE=1) -> outValid=0 and inReady=1 immediately after rst deasserts; the next block produces a correct result with no residue from the aborted block.
